// File: rtl/ti_tone_noise_gen.sv
// SN76489-compatible PSG core: CPU byte-write register file, three square-wave
// tone channels and one LFSR noise channel, all advanced by an internal prescaler tick.
module ti_tone_noise_gen #(
  parameter int                CLK_DIV   = 16,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'h8000,
  parameter int                WHITE_TAP = 3
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic       ch0out,
  output logic       ch1out,
  output logic       ch2out,
  output logic       ch3out,
  output logic       tick
);

  localparam int            PW           = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLK_DIV - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [3:0][3:0]     vol_q, vol_d;
  logic [2:0][9:0]     period_q, period_d;
  logic [2:0][9:0]     cnt_q, cnt_d;
  logic [2:0]          tone_q, tone_d;
  logic [2:0]          nctl_q, nctl_d;
  logic [6:0]          ncnt_q, ncnt_d;
  logic                nff_q, nff_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [1:0]          latch_ch_q, latch_ch_d;
  logic                latch_vol_q, latch_vol_d;

  logic                tick_now;
  logic [2:0]          tone_ev;
  logic                noise_ev;
  logic                fb;
  logic [6:0]          noise_reload;
  logic [1:0]          sel_ch;
  logic                sel_vol;

  assign tick_now     = (presc_q == '0);
  assign fb           = nctl_q[2] ? (lfsr_q[0] ^ lfsr_q[WHITE_TAP]) : lfsr_q[0];
  assign noise_reload = 7'd16 << nctl_q[1:0];

  always_comb begin
    presc_d     = tick_now ? PRESC_RELOAD : presc_q - PW'(1);
    vol_d       = vol_q;
    period_d    = period_q;
    cnt_d       = cnt_q;
    tone_d      = tone_q;
    nctl_d      = nctl_q;
    ncnt_d      = ncnt_q;
    nff_d       = nff_q;
    lfsr_d      = lfsr_q;
    latch_ch_d  = latch_ch_q;
    latch_vol_d = latch_vol_q;
    tone_ev     = '0;
    noise_ev    = 1'b0;
    sel_ch      = latch_ch_q;
    sel_vol     = latch_vol_q;

    // Generator step sees only the pre-write register values.
    if (tick_now) begin
      for (int i = 0; i < 3; i++) begin
        if (period_q[i] <= 10'd1) begin
          cnt_d[i]  = period_q[i];
          tone_d[i] = 1'b1;
        end else if (cnt_q[i] <= 10'd1) begin
          cnt_d[i]   = period_q[i];
          tone_d[i]  = ~tone_q[i];
          tone_ev[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 10'd1;
        end
      end
      if (nctl_q[1:0] == 2'd3) begin
        noise_ev = tone_ev[2];
      end else if (ncnt_q <= 7'd1) begin
        ncnt_d   = noise_reload;
        noise_ev = 1'b1;
      end else begin
        ncnt_d = ncnt_q - 7'd1;
      end
      if (noise_ev) begin
        nff_d = ~nff_q;
        if (!nff_q) lfsr_d = {fb, lfsr_q[LFSR_W-1:1]};
      end
    end

    if (wr_en && wr_data[7]) begin
      sel_ch      = wr_data[6:5];
      sel_vol     = wr_data[4];
      latch_ch_d  = wr_data[6:5];
      latch_vol_d = wr_data[4];
    end

    // A noise-control write overrides any LFSR shift in the same cycle.
    if (wr_en) begin
      if (sel_vol) begin
        vol_d[sel_ch] = wr_data[3:0];
      end else if (sel_ch == 2'd3) begin
        nctl_d = wr_data[2:0];
        lfsr_d = LFSR_SEED;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (sel_ch == 2'(i)) begin
            if (wr_data[7]) period_d[i][3:0] = wr_data[3:0];
            else            period_d[i][9:4] = wr_data[5:0];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      presc_q     <= PRESC_RELOAD;
      vol_q       <= {4{4'hF}};
      period_q    <= '0;
      cnt_q       <= '0;
      tone_q      <= '1;
      nctl_q      <= '0;
      ncnt_q      <= '0;
      nff_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      latch_ch_q  <= '0;
      latch_vol_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      vol_q       <= vol_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      tone_q      <= tone_d;
      nctl_q      <= nctl_d;
      ncnt_q      <= ncnt_d;
      nff_q       <= nff_d;
      lfsr_q      <= lfsr_d;
      latch_ch_q  <= latch_ch_d;
      latch_vol_q <= latch_vol_d;
    end
  end

  assign vol0   = vol_q[0];
  assign vol1   = vol_q[1];
  assign vol2   = vol_q[2];
  assign vol3   = vol_q[3];
  assign ch0out = tone_q[0];
  assign ch1out = tone_q[1];
  assign ch2out = tone_q[2];
  assign ch3out = lfsr_q[0];
  assign tick   = tick_now;

endmodule

// File: tb/tb_ti_tone_noise_gen.sv
// Self-checking bench for ti_tone_noise_gen: directed scenarios plus random writes,
// every cycle compared against a cycle-count based behavioural model.
module tb_ti_tone_noise_gen;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic       ch0out, ch1out, ch2out, ch3out, tick;

  ti_tone_noise_gen dut (
    .CLK(CLK), .nRST(nRST), .wr_en(wr_en), .wr_data(wr_data),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .ch0out(ch0out), .ch1out(ch1out), .ch2out(ch2out), .ch3out(ch3out),
    .tick(tick)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [3:0]  m_vol [4];
  int          m_per [3];
  int          m_cnt [3];
  bit          m_out [3];
  int          m_nctl, m_ncnt, m_lch, m_n, m_shifts;
  bit          m_nff, m_lvol;
  logic [15:0] m_lfsr;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_vol[i] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      m_per[i] = 0;
      m_cnt[i] = 0;
      m_out[i] = 1'b1;
    end
    m_nctl = 0; m_ncnt = 0; m_nff = 1'b0; m_lfsr = 16'h8000;
    m_lch = 0; m_lvol = 1'b0; m_n = 0;
  endtask

  // One clock edge: generator tick (on every 16th edge) first, then the write.
  task automatic model_step(input bit en, input logic [7:0] d);
    bit ev2, nev, fbit;
    ev2 = 1'b0;
    nev = 1'b0;
    if (m_n % 16 == 15) begin
      for (int i = 0; i < 3; i++) begin
        if (m_per[i] <= 1) begin
          m_out[i] = 1'b1;
          m_cnt[i] = m_per[i];
        end else if (m_cnt[i] <= 1) begin
          m_cnt[i] = m_per[i];
          m_out[i] = !m_out[i];
          if (i == 2) ev2 = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
      if ((m_nctl & 3) == 3) nev = ev2;
      else if (m_ncnt <= 1) begin
        m_ncnt = 16 << (m_nctl & 3);
        nev = 1'b1;
      end else m_ncnt = m_ncnt - 1;
      if (nev) begin
        m_nff = !m_nff;
        if (m_nff) begin
          fbit = m_lfsr[0] ^ (((m_nctl & 4) != 0) ? m_lfsr[3] : 1'b0);
          m_lfsr = {fbit, m_lfsr[15:1]};
          m_shifts++;
        end
      end
    end
    if (en) begin
      if (d[7]) begin
        m_lch  = int'(d[6:5]);
        m_lvol = d[4];
      end
      if (m_lvol) m_vol[m_lch] = d[3:0];
      else if (m_lch == 3) begin
        m_nctl = int'(d[2:0]);
        m_lfsr = 16'h8000;
      end else if (d[7]) m_per[m_lch] = (m_per[m_lch] & 'h3F0) | int'(d[3:0]);
      else m_per[m_lch] = (m_per[m_lch] & 'hF) | (int'(d[5:0]) << 4);
    end
    m_n++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {11'd0, vol3, vol2, vol1, vol0, ch3out, ch2out, ch1out, ch0out, tick};
  endfunction

  function automatic logic [31:0] model_vec();
    return {11'd0, m_vol[3], m_vol[2], m_vol[1], m_vol[0], m_lfsr[0],
            m_out[2], m_out[1], m_out[0], (m_n % 16 == 15)};
  endfunction

  // Drive one cycle of input, step the model at the edge, compare on the falling edge.
  task automatic applyStimulus(input bit en, input logic [7:0] d);
    wr_en   = en;
    wr_data = d;
    @(posedge CLK);
    if (nRST) model_step(en, d);
    cyc++;
    @(negedge CLK);
    checkOutput("outputs", dut_vec(), model_vec());
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  initial begin
    int t_first, t_second, ntog, s0, shift1_cyc;
    int tog [3];
    bit prev, seen1, seen13;

    nRST = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    model_reset();
    m_shifts = 0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_vols", {vol3, vol2, vol1, vol0}, 16'hFFFF);
    checkOutput("reset_tones", {ch2out, ch1out, ch0out}, 3'b111);
    checkOutput("reset_ch3out", ch3out, 1'b0);
    checkOutput("reset_tick", tick, 1'b0);
    nRST = 1'b1;

    t_first = -1; t_second = -1;
    for (int i = 0; i < 40 && t_second < 0; i++) begin
      applyStimulus(1'b0, 8'h00);
      if (tick) begin
        if (t_first < 0) t_first = cyc;
        else t_second = cyc;
      end
    end
    checkOutput("first_tick_cycle", t_first, 15);
    checkOutput("tick_spacing", t_second - t_first, 16);

    applyStimulus(1'b1, 8'h8E);
    applyStimulus(1'b1, 8'h03);
    ntog = 0;
    prev = ch0out;
    for (int i = 0; i < 3500 && ntog < 3; i++) begin
      applyStimulus(1'b0, 8'h00);
      if (ch0out != prev) begin
        tog[ntog] = cyc;
        ntog++;
        prev = ch0out;
      end
    end
    checkOutput("ch0_toggle_count", ntog, 3);
    if (ntog == 3) checkOutput("ch0_half_period", tog[2] - tog[1], 992);

    applyStimulus(1'b1, 8'h9A);
    checkOutput("vol0_latch", vol0, 4'hA);
    applyStimulus(1'b1, 8'h05);
    checkOutput("vol0_data", vol0, 4'h5);

    applyStimulus(1'b1, 8'hE4);
    checkOutput("white_seed_model", m_lfsr, 16'h8000);
    checkOutput("white_seed_ch3", ch3out, 1'b0);
    s0 = m_shifts; seen1 = 1'b0; seen13 = 1'b0; shift1_cyc = 0;
    for (int i = 0; i < 52500 && (m_shifts - s0) < 100; i++) begin
      applyStimulus(1'b0, 8'h00);
      if (!seen1 && m_shifts - s0 == 1) begin
        seen1 = 1'b1;
        shift1_cyc = cyc;
        checkOutput("white_first_shift", m_lfsr, 16'h4000);
      end
      if (!seen13 && m_shifts - s0 == 13) begin
        seen13 = 1'b1;
        checkOutput("white_shift13", m_lfsr, 16'h8004);
        checkOutput("white_shift_spacing", cyc - shift1_cyc, 12 * 512);
      end
    end
    checkOutput("white_shift_count", m_shifts - s0, 100);

    applyStimulus(1'b1, 8'hC0);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'hE3);
    checkOutput("periodic_seed_model", m_lfsr, 16'h8000);
    s0 = m_shifts;
    idle(64 * 16);
    checkOutput("periodic_no_shift", m_shifts - s0, 0);
    checkOutput("periodic_hold_ch3", ch3out, 1'b0);
    applyStimulus(1'b1, 8'hC8);
    applyStimulus(1'b1, 8'h00);
    s0 = m_shifts; seen1 = 1'b0;
    for (int i = 0; i < 4700 && (m_shifts - s0) < 16; i++) begin
      applyStimulus(1'b0, 8'h00);
      if (!seen1 && m_shifts - s0 == 1) begin
        seen1 = 1'b1;
        checkOutput("periodic_first_shift", m_lfsr, 16'h4000);
      end
    end
    checkOutput("periodic_shift_count", m_shifts - s0, 16);
    checkOutput("periodic_wrap", m_lfsr, 16'h8000);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      applyStimulus($urandom_range(0, 3) == 0, d);
    end

    applyStimulus(1'b1, 8'h85);
    applyStimulus(1'b1, 8'h00);
    idle(200);
    wr_en = 1'b1;
    wr_data = 8'h91;
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    checkOutput("async_vols", {vol3, vol2, vol1, vol0}, 16'hFFFF);
    checkOutput("async_tones", {ch2out, ch1out, ch0out}, 3'b111);
    checkOutput("async_ch3_tick", {ch3out, tick}, 2'b00);
    @(negedge CLK);
    wr_en = 1'b0;
    idle(3);
    nRST = 1'b1;
    idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
